// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32 opcode map, unit selects and operand-usage decode shared by the issue queues
package riscv_pkg;
   localparam int OPC_W = 7;
   localparam int REG_W = 5;
   localparam int NREGS = 32;
   localparam int RD_LSB = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam logic [OPC_W-1:0] OP = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] JAL = 7'b1101111;
   localparam logic [OPC_W-1:0] JALR = 7'b1100111;
   localparam logic [OPC_W-1:0] LUI = 7'b0110111;
   localparam logic [OPC_W-1:0] AUIPC = 7'b0010111;
   localparam logic [OPC_W-1:0] LOAD = 7'b0000011;
   localparam logic [OPC_W-1:0] STORE = 7'b0100011;
   localparam logic [OPC_W-1:0] LOAD_FP = 7'b0000111;
   localparam logic [OPC_W-1:0] STORE_FP = 7'b0100111;
   localparam logic [OPC_W-1:0] OP_FP = 7'b1010011;
   localparam logic [OPC_W-1:0] FMADD = 7'b1000011;
   localparam logic [OPC_W-1:0] FMSUB = 7'b1000111;
   localparam logic [OPC_W-1:0] FNMSUB = 7'b1001011;
   localparam logic [OPC_W-1:0] FNMADD = 7'b1001111;
   localparam logic [1:0] INTALU = 2'b00;
   localparam logic [1:0] FPALU = 2'b01;
   localparam logic [1:0] AGU = 2'b10;
   function automatic logic uses_rs1(input logic [OPC_W-1:0] opc);
      return !(opc inside {LUI, AUIPC, JAL});
   endfunction
   function automatic logic uses_rs2(input logic [OPC_W-1:0] opc);
      return opc inside {OP, BRANCH, STORE, STORE_FP, OP_FP, FMADD, FMSUB, FNMSUB, FNMADD};
   endfunction
   function automatic logic writes_rd(input logic [OPC_W-1:0] opc);
      return !(opc inside {BRANCH, STORE, STORE_FP});
   endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: 32 pending-write bits with set-over-clear priority and two combinational read ports
module reg_scoreboard
   import riscv_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             set_en_i,
   input  logic [REG_W-1:0] set_idx_i,
   input  logic             clr_en_i,
   input  logic [REG_W-1:0] clr_idx_i,
   input  logic [REG_W-1:0] rd_a_i,
   input  logic [REG_W-1:0] rd_b_i,
   output logic             busy_a_o,
   output logic             busy_b_o
);
   logic [NREGS-1:0] busy_q, busy_d;
   // set applied after clear: the issuing writer is newer than the one writing back
   always_comb begin
      busy_d = busy_q;
      if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
      if (set_en_i) busy_d[set_idx_i] = 1'b1;
      busy_d[0] = 1'b0;
      if (flush_i) busy_d = '0;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) busy_q <= '0;
      else busy_q <= busy_d;
   assign busy_a_o = busy_q[rd_a_i];
   assign busy_b_o = busy_q[rd_b_i];
endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order instruction buffer that issues its head once the local scoreboard clears its sources
module issue_queue
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8,
   parameter int CNTW  = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             enq,
   input  logic [XLEN-1:0]  data_in,
   output logic             full,
   output logic             empty,
   output logic [CNTW-1:0]  count,
   output logic             overflow,
   output logic             issue_valid,
   input  logic             issue_ready,
   output logic [XLEN-1:0]  issue_data,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_rd
);
   localparam int PW = $clog2(DEPTH);
   logic [XLEN-1:0] mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNTW-1:0] count_q, count_d;
   logic overflow_q, overflow_d;
   logic [OPC_W-1:0] opc;
   logic [REG_W-1:0] rs1, rs2, rd;
   logic busy1, busy2, do_enq, do_iss, set_en;
   assign issue_data = mem_q[head_q];
   assign opc = issue_data[OPC_W-1:0];
   assign rs1 = issue_data[RS1_LSB +: REG_W];
   assign rs2 = issue_data[RS2_LSB +: REG_W];
   assign rd = issue_data[RD_LSB +: REG_W];
   assign full = count_q == CNTW'(DEPTH);
   assign empty = count_q == '0;
   assign count = count_q;
   assign overflow = overflow_q;
   assign issue_valid = !empty && !(uses_rs1(opc) && busy1) && !(uses_rs2(opc) && busy2);
   // full comes from registered count, so an issue this cycle never frees a slot for this cycle's enq
   assign do_enq = enq && !full;
   assign do_iss = issue_valid && issue_ready;
   assign set_en = do_iss && writes_rd(opc) && rd != '0;
   always_comb begin
      head_d = flush ? '0 : head_q + PW'(do_iss);
      tail_d = flush ? '0 : tail_q + PW'(do_enq);
      count_d = flush ? '0 : count_q + CNTW'(do_enq) - CNTW'(do_iss);
      overflow_d = !flush && (overflow_q || (enq && full));
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
         overflow_q <= overflow_d;
      end
   always_ff @(posedge clk)
      if (do_enq && !flush) mem_q[tail_q] <= data_in;
   reg_scoreboard u_sb (
      .clk       (clk),
      .reset     (reset),
      .flush_i   (flush),
      .set_en_i  (set_en),
      .set_idx_i (rd),
      .clr_en_i  (wb_valid && wb_rd != '0),
      .clr_idx_i (wb_rd),
      .rd_a_i    (rs1),
      .rd_b_i    (rs2),
      .busy_a_o  (busy1),
      .busy_b_o  (busy2)
   );
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed + random stimulus against a queue-level reference model with an issue scoreboard
module tb_issue_queue;
   localparam int DEPTH = 8;
   localparam bit [6:0] OPS [16] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                                     7'b1100111, 7'b0110111, 7'b0010111, 7'b0000011,
                                     7'b0100011, 7'b0000111, 7'b0100111, 7'b1010011,
                                     7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111};
   logic clk = 0, reset = 1, flush = 0, enq = 0, issue_ready = 0, wb_valid = 0;
   logic [31:0] data_in = 0;
   logic [4:0] wb_rd = 0;
   logic full, empty, overflow, issue_valid;
   logic [3:0] count;
   logic [31:0] issue_data;
   int total = 0, bad = 0;
   bit [31:0] mq[$], sbq[$];
   bit pend [32];
   bit movf, mv, macc;
   bit [31:0] mh, me;
   always #5 clk = ~clk;
   issue_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush), .enq(enq), .data_in(data_in),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_data(issue_data),
      .wb_valid(wb_valid), .wb_rd(wb_rd)
   );
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic bit m_rs1(bit [6:0] o);
      return !(o == 7'b0110111 || o == 7'b0010111 || o == 7'b1101111);
   endfunction
   function automatic bit m_rs2(bit [6:0] o);
      return o == 7'b0110011 || o == 7'b1100011 || o == 7'b0100011 || o == 7'b0100111 ||
             o == 7'b1010011 || o == 7'b1000011 || o == 7'b1000111 || o == 7'b1001011 ||
             o == 7'b1001111;
   endfunction
   function automatic bit m_rd(bit [6:0] o);
      return !(o == 7'b1100011 || o == 7'b0100011 || o == 7'b0100111);
   endfunction
   function automatic bit [31:0] addi(int rd, int rs, int imm);
      return {12'(imm), 5'(rs), 3'b000, 5'(rd), 7'b0010011};
   endfunction
   function automatic bit [31:0] rnd_insn();
      bit [31:0] w = $urandom;
      w[6:0] = OPS[$urandom % 16];
      w[11:7] = 5'($urandom % 8);
      w[19:15] = 5'($urandom % 8);
      w[24:20] = 5'($urandom % 8);
      return w;
   endfunction
   // reference model: a plain word queue plus a pending-register set, evaluated mid-cycle
   always @(negedge clk) begin
      if (reset) begin
         mq.delete();
         sbq.delete();
         pend = '{default: 0};
         movf = 0;
      end else begin
         mh = mq.size() != 0 ? mq[0] : 32'h0;
         mv = mq.size() != 0 && !(m_rs1(mh[6:0]) && pend[mh[19:15]]) && !(m_rs2(mh[6:0]) && pend[mh[24:20]]);
         chk("count", 32'(count), mq.size());
         chk("full", 32'(full), 32'(mq.size() == DEPTH));
         chk("empty", 32'(empty), 32'(mq.size() == 0));
         chk("overflow", 32'(overflow), 32'(movf));
         chk("issue_valid", 32'(issue_valid), 32'(mv));
         if (mq.size() != 0) chk("head_word", issue_data, mh);
         if (flush) begin
            mq.delete();
            sbq.delete();
            pend = '{default: 0};
            movf = 0;
         end else begin
            macc = enq && mq.size() < DEPTH;
            if (enq && !macc) movf = 1;
            if (wb_valid && wb_rd != 0) pend[wb_rd] = 0;
            if (mv && issue_ready) begin
               void'(mq.pop_front());
               if (m_rd(mh[6:0]) && mh[11:7] != 0) pend[mh[11:7]] = 1;
            end
            if (macc) begin
               mq.push_back(data_in);
               sbq.push_back(data_in);
            end
         end
      end
   end
   always @(negedge clk)
      if (!reset && !flush && issue_valid && issue_ready) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL issue_unexpected: got %h want none at %0t", issue_data, $time);
         end else begin
            me = sbq.pop_front();
            chk("issued_word", issue_data, me);
         end
      end
   task automatic step(bit e, bit [31:0] d, bit r, bit wv = 0, bit [4:0] wr = 0, bit fl = 0);
      enq = e;
      data_in = d;
      issue_ready = r;
      wb_valid = wv;
      wb_rd = wr;
      flush = fl;
      @(posedge clk);
      #1;
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 0;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_valid", 32'(issue_valid), 0);
      chk("rst_ovf", 32'(overflow), 0);
      for (int i = 0; i < 9; i++) step(1, addi(5 + i, 0, 1), 0);
      chk("fill_full", 32'(full), 1);
      chk("fill_count", 32'(count), 8);
      chk("fill_ovf", 32'(overflow), 1);
      repeat (10) step(0, 0, 1);
      chk("drain_empty", 32'(empty), 1);
      chk("ovf_sticky", 32'(overflow), 1);
      step(0, 0, 0, 0, 0, 1);
      chk("flush_ovf", 32'(overflow), 0);
      step(1, 32'h002081B3, 1);
      step(1, 32'h00118213, 1);
      repeat (3) step(0, 0, 1);
      chk("raw_stall", 32'(issue_valid), 0);
      chk("raw_head", issue_data, 32'h00118213);
      step(0, 0, 1, 1, 3);
      chk("raw_wake", 32'(issue_valid), 1);
      step(0, 0, 1);
      chk("raw_done", 32'(empty), 1);
      step(1, 32'h002081B3, 1);
      step(0, 0, 1);
      step(1, 32'h002081B3, 1);
      step(0, 0, 1, 1, 3);
      step(1, 32'h00118213, 1);
      repeat (2) step(0, 0, 1);
      chk("collide_set_wins", 32'(issue_valid), 0);
      step(0, 0, 1, 1, 3);
      step(0, 0, 1);
      step(0, 0, 1, 1, 4);
      for (int i = 0; i < 4; i++) step(1, addi(5 + i, 0, i + 1), 0);
      repeat (5) begin
         step(0, 0, 0);
         chk("bp_data", issue_data, addi(5, 0, 1));
         chk("bp_count", 32'(count), 4);
      end
      step(1, addi(9, 0, 7), 1);
      chk("bp_enq_iss_count", 32'(count), 4);
      repeat (6) step(0, 0, 1);
      step(1, 32'h002081B3, 1);
      step(1, 32'h00118213, 1);
      for (int i = 0; i < 4; i++) step(1, addi(20 + i, 0, 1), 0);
      chk("fl_count5", 32'(count), 5);
      step(0, 0, 0, 0, 0, 1);
      chk("fl_empty", 32'(empty), 1);
      chk("fl_count0", 32'(count), 0);
      step(1, 32'h00118213, 1);
      chk("fl_busy_clear", 32'(issue_valid), 1);
      step(0, 0, 1);
      for (int i = 0; i < 9; i++) step(1, addi(5 + i, 0, 2), 0);
      #2 reset = 1;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_empty", 32'(empty), 1);
      chk("arst_full", 32'(full), 0);
      chk("arst_valid", 32'(issue_valid), 0);
      chk("arst_ovf", 32'(overflow), 0);
      enq = 0;
      @(posedge clk);
      #1 reset = 0;
      for (int i = 0; i < 600; i++)
         step($urandom % 3 != 0, rnd_insn(), $urandom % 4 != 0, $urandom % 3 == 0,
              5'($urandom % 8), $urandom % 97 == 0);
      step(0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
